// File: rtl/fmlmemtest_pkg.sv
// fmlmemtest_pkg: shared constants, register map, FSM encoding and LFSR step for the FML memory tester.
package fmlmemtest_pkg;
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_NBURSTS = 3'd1;
  localparam logic [2:0] REG_BASE    = 3'd2;
  localparam logic [2:0] REG_ERRCNT  = 3'd3;
  localparam logic [2:0] REG_SEED    = 3'd4;
  localparam logic [2:0] REG_ERRADDR = 3'd5;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam int BEATS  = 4;
  localparam int STRIDE = 16;
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_e;
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
  endfunction
endpackage

// File: rtl/fmlmemtest_if.sv
// fmlmemtest_if: CSR slave port plus FML 4x32 initiator port of the memory tester.
interface fmlmemtest_if #(parameter int fml_depth = 26);
  logic [13:0] csr_a;
  logic csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic [fml_depth-1:0] fml_adr;
  logic fml_stb;
  logic fml_we;
  logic fml_ack;
  logic [3:0] fml_sel;
  logic [31:0] fml_do;
  logic [31:0] fml_di;
  modport master (
    input  csr_a, csr_we, csr_di, fml_ack, fml_di,
    output csr_do, fml_adr, fml_stb, fml_we, fml_sel, fml_do
  );
  modport slave (
    output csr_a, csr_we, csr_di, fml_ack, fml_di,
    input  csr_do, fml_adr, fml_stb, fml_we, fml_sel, fml_do
  );
endinterface

// File: rtl/fmlmemtest_lfsr.sv
// fmlmemtest_lfsr: 32-bit Galois LFSR with seed load (zero seed becomes 1) and per-beat advance.
module fmlmemtest_lfsr
  import fmlmemtest_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_adv,
  input  logic [31:0] i_seed,
  output logic [31:0] o_q
);
  logic [31:0] r_q;
  always_ff @(posedge clk)
    if (rst) r_q <= 32'h0;
    else if (i_load) r_q <= (i_seed == 32'h0) ? 32'h1 : i_seed;
    else if (i_adv) r_q <= lfsr_next(r_q);
  assign o_q = r_q;
endmodule

// File: rtl/fmlmemtest.sv
// fmlmemtest: FML 4x32 LFSR fill/verify engine configured over CSR.
// Define FMLMEMTEST_ERRADDR_EN to build register 5, the first-mismatch byte address.
module fmlmemtest
  import fmlmemtest_pkg::*;
#(
  parameter logic [3:0] csr_addr  = 4'h0,
  parameter int         fml_depth = 26
) (
  input logic          sys_clk,
  input logic          sys_rst,
  fmlmemtest_if.master bus
);
  state_e r_state, w_next;
  logic r_mode;
  logic [31:0] r_nbursts, r_seed, r_errcnt, r_cnt, r_csr_do;
  logic [fml_depth-1:0] r_base, r_adr;
  logic [1:0] r_beat;
  logic w_sel, w_wr, w_start, w_beat, w_last, w_clr, w_mis;
  logic [2:0] w_reg;
  logic [31:0] w_lfsr, w_rd, w_erraddr;
  assign w_sel   = bus.csr_a[13:10] == csr_addr;
  assign w_reg   = bus.csr_a[2:0];
  assign w_wr    = w_sel & bus.csr_we;
  assign w_start = w_wr & (w_reg == REG_CTRL) & bus.csr_di[0] & (r_state == IDLE) & (r_nbursts != 32'h0);
  assign w_beat  = r_state == DATA;
  assign w_last  = w_beat & (r_beat == 2'(BEATS - 1));
  assign w_clr   = w_wr & (w_reg == REG_ERRCNT);
  assign w_mis   = w_beat & ~r_mode & (bus.fml_di != w_lfsr);

  fmlmemtest_lfsr u_lfsr (
    .clk(sys_clk),
    .rst(sys_rst),
    .i_load(w_start),
    .i_adv(w_beat),
    .i_seed(r_seed),
    .o_q(w_lfsr)
  );

  always_ff @(posedge sys_clk) r_state <= sys_rst ? IDLE : w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = REQ;
      REQ:     if (bus.fml_ack) w_next = DATA;
      DATA:    if (w_last) w_next = (r_cnt == 32'd1) ? IDLE : REQ;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.fml_stb = r_state == REQ;
    bus.fml_we  = (r_state != IDLE) & r_mode;
    bus.fml_sel = (w_beat & r_mode) ? 4'hf : 4'h0;
    bus.fml_do  = (w_beat & r_mode) ? w_lfsr : 32'h0;
  end
  assign bus.fml_adr = r_adr;
  assign bus.csr_do  = r_csr_do;

  // Config registers are only snapshotted on start, so writes while busy leave the pass alone.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_mode    <= 1'b0;
      r_nbursts <= 32'h0;
      r_base    <= '0;
      r_seed    <= 32'h1;
      r_errcnt  <= 32'h0;
      r_cnt     <= 32'h0;
      r_adr     <= '0;
      r_beat    <= 2'd0;
      r_csr_do  <= 32'h0;
    end else begin
      if (w_wr && w_reg == REG_NBURSTS) r_nbursts <= bus.csr_di;
      if (w_wr && w_reg == REG_BASE) r_base <= {bus.csr_di[fml_depth-1:4], 4'h0};
      if (w_wr && w_reg == REG_SEED) r_seed <= bus.csr_di;
      if (w_wr && w_reg == REG_CTRL && r_state == IDLE) r_mode <= bus.csr_di[1];
      if (w_start) begin
        r_cnt <= r_nbursts;
        r_adr <= r_base;
      end else if (w_last) begin
        r_cnt <= r_cnt - 32'd1;
        r_adr <= r_adr + fml_depth'(STRIDE);
      end
      r_beat   <= w_beat ? r_beat + 2'd1 : 2'd0;
      r_errcnt <= w_clr ? 32'h0 : (w_mis && r_errcnt != '1) ? r_errcnt + 32'd1 : r_errcnt;
      r_csr_do <= w_rd;
    end
  end

`ifdef FMLMEMTEST_ERRADDR_EN
  logic [fml_depth-1:0] r_erraddr;
  always_ff @(posedge sys_clk)
    if (sys_rst || w_clr) r_erraddr <= '0;
    else if (w_mis && r_errcnt == 32'h0) r_erraddr <= r_adr + fml_depth'({r_beat, 2'b00});
  assign w_erraddr = 32'(r_erraddr);
`else
  assign w_erraddr = 32'h0;
`endif

  always_comb begin
    w_rd = 32'h0;
    if (w_sel)
      w_rd = (w_reg == REG_CTRL)    ? {30'h0, r_mode, r_state != IDLE} :
             (w_reg == REG_NBURSTS) ? r_nbursts :
             (w_reg == REG_BASE)    ? 32'(r_base) :
             (w_reg == REG_ERRCNT)  ? r_errcnt :
             (w_reg == REG_SEED)    ? r_seed :
             (w_reg == REG_ERRADDR) ? w_erraddr : 32'h0;
  end
endmodule
